serial_transmitter: RTL and testbench

Upstream partner of the serial word receiver in the exchange link. Accepts parallel WIDTH-bit words from the order/quote logic through a valid/ready interface and buffers them in a small FIFO. Each word goes out MSB-first on a single data line, with comEn held high for exactly WIDTH consecutive cycles per word. The receiver shifts in `datain` on every cycle where comEn is high and drops a partial word if comEn falls early, so this block never deasserts comEn mid-word.

---
 rtl/serial_link_pkg.sv | 13 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/serial_transmitter.sv | 124 ++++++++++++
 tb/tb_serial_transmitter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial exchange link (transmitter and receiver).
// LINK_WIDTH is the frame length both ends must agree on.
package serial_link_pkg;

  localparam int unsigned LINK_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO buffering words ahead of the serializer.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push, push_data     write request (ignored while full)
//   pop, pop_data       read request (ignored while empty); pop_data shows the head word
//   full, empty, count  occupancy, all derived from the registered count
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full     = (count_q == (PtrW + 1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/serial_transmitter.sv
// Serializes buffered parallel words MSB-first onto a single data line, framing
// each word with comEn held high for exactly WIDTH consecutive cycles.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   wr_data, wr_valid   word to send; accepted when wr_valid && wr_ready
//   wr_ready            FIFO has room
//   dataout, comEn      serial bit and frame enable toward the receiver
//   busy                a frame or gap is in progress, or words are queued
//   word_sent           pulse while the LSB of a word is on dataout
module serial_transmitter #(
  parameter int unsigned WIDTH = serial_link_pkg::LINK_WIDTH,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic             dataout,
  output logic             comEn,
  output logic             busy,
  output logic             word_sent
);

  import serial_link_pkg::*;

  localparam int unsigned CntW = $clog2(WIDTH);
  // The gap counter is never used when GAP is 0; keep it one bit wide then.
  localparam int unsigned GapW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP > 0) ? GAP - 1 : 0);

  tx_state_t         state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;

  logic                   fifo_pop;
  logic [WIDTH-1:0]       fifo_data;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_valid),
    .push_data(wr_data),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shreg_d   = fifo_data;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d   = shreg_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LastBit) begin
          if (GAP > 0) begin
            gap_cnt_d = '0;
            state_d   = serial_link_pkg::GAP;
          end else if (!fifo_empty) begin
            // Back-to-back frames: reload without dropping comEn.
            fifo_pop  = 1'b1;
            shreg_d   = fifo_data;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      serial_link_pkg::GAP: begin
        if (gap_cnt_q == GapLast) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    comEn     = (state_q == SHIFT);
    dataout   = comEn && shreg_q[WIDTH-1];
    word_sent = comEn && (bit_cnt_q == LastBit);
    busy      = (state_q != IDLE) || (fifo_count != '0);
    wr_ready  = !fifo_full;
  end

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench for serial_transmitter: one instance with GAP=0 and one with
// GAP=3, each followed by a small receiver model that shifts dataout while
// comEn is high and drops partial words when comEn falls.
module tb_serial_transmitter;

  logic        clk = 1'b0;
  logic        rst0, rst3;
  logic [31:0] wd0, wd3;
  logic        wv0, wv3;
  logic        wr0, do0, ce0, busy0, ws0;
  logic        wr3, do3, ce3, busy3, ws3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_transmitter #(.WIDTH(32), .DEPTH(4), .GAP(0)) u_dut0 (
    .clk(clk), .reset(rst0), .wr_data(wd0), .wr_valid(wv0), .wr_ready(wr0),
    .dataout(do0), .comEn(ce0), .busy(busy0), .word_sent(ws0)
  );

  serial_transmitter #(.WIDTH(32), .DEPTH(4), .GAP(3)) u_dut3 (
    .clk(clk), .reset(rst3), .wr_data(wd3), .wr_valid(wv3), .wr_ready(wr3),
    .dataout(do3), .comEn(ce3), .busy(busy3), .word_sent(ws3)
  );

  // Receiver models
  logic [31:0] rxq0[$];
  logic [31:0] rxq3[$];
  logic [31:0] rsh0, rsh3;
  int          rn0 = 0;
  int          rn3 = 0;

  always @(negedge clk) begin
    if (ce0) begin
      rsh0 = {rsh0[30:0], do0};
      rn0  = rn0 + 1;
      if (rn0 == 32) begin
        rxq0.push_back(rsh0);
        rn0 = 0;
      end
    end else begin
      rn0 = 0;
    end
  end

  always @(negedge clk) begin
    if (ce3) begin
      rsh3 = {rsh3[30:0], do3};
      rn3  = rn3 + 1;
      if (rn3 == 32) begin
        rxq3.push_back(rsh3);
        rn3 = 0;
      end
    end else begin
      rn3 = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic cen(input int w);
    return (w == 0) ? ce0 : ce3;
  endfunction

  // Presents a word from the next negedge until it is accepted; reports how
  // many negedges it saw wr_ready low.
  task automatic push(input int w, input logic [31:0] d, output int waits);
    waits = 0;
    @(negedge clk);
    if (w == 0) begin wd0 = d; wv0 = 1'b1; end
    else        begin wd3 = d; wv3 = 1'b1; end
    while (((w == 0) ? wr0 : wr3) == 1'b0 && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 100) check("push_timeout", waits, 0);
    @(posedge clk);
    #1;
    if (w == 0) wv0 = 1'b0;
    else        wv3 = 1'b0;
  endtask

  // Counts consecutive comEn-high negedges starting at the current one.
  task automatic count_high(input int w, output int run);
    run = 0;
    while (cen(w) && run < 300) begin
      run++;
      @(negedge clk);
    end
  endtask

  task automatic count_low(input int w, output int run);
    run = 0;
    while (!cen(w) && run < 100) begin
      run++;
      @(negedge clk);
    end
  endtask

  task automatic wait_high(input int w, output int run);
    int t;
    t = 0;
    @(negedge clk);
    while (!cen(w) && t < 100) begin
      t++;
      @(negedge clk);
    end
    count_high(w, run);
  endtask

  task automatic wait_rx(input int w, input int n);
    int t;
    t = 0;
    while (((w == 0) ? rxq0.size() : rxq3.size()) < n && t < 600) begin
      t++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int w);
    int t;
    t = 0;
    @(negedge clk);
    while (((w == 0) ? busy0 : busy3) && t < 600) begin
      t++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w, run;
    int          wts[6];
    logic [31:0] bits, wsm;
    int          hi;
    logic [31:0] words[6];

    rst0 = 1'b1; rst3 = 1'b1;
    wv0 = 1'b0;  wv3 = 1'b0;
    wd0 = '0;    wd3 = '0;
    repeat (3) @(negedge clk);

    // Reset values: {comEn, dataout, busy, word_sent, wr_ready}
    check("rst0_outs", {ce0, do0, busy0, ws0, wr0}, 32'b00001);
    check("rst3_outs", {ce3, do3, busy3, ws3, wr3}, 32'b00001);
    rst0 = 1'b0; rst3 = 1'b0;
    repeat (2) @(negedge clk);

    // Single word: load one cycle after the write, 32 framed bits
    push(0, 32'hA5A50F0F, w);
    @(negedge clk);
    check("t1_pre_comen", ce0, 0);
    check("t1_pre_busy", busy0, 1);
    bits = '0; wsm = '0; hi = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bits = {bits[30:0], do0};
      wsm  = {wsm[30:0], ws0};
      hi   = hi + int'(ce0);
    end
    check("t1_bits", bits, 32'hA5A50F0F);
    check("t1_word_sent_pos", wsm, 32'h0000_0001);
    check("t1_comen_cycles", hi, 32);
    @(negedge clk);
    check("t1_post_outs", {ce0, do0, busy0, ws0}, 32'b0000);
    check("t1_rx_count", rxq0.size(), 1);
    if (rxq0.size() > 0) check("t1_rx_word", rxq0.pop_front(), 32'hA5A50F0F);

    // Back-to-back frames with GAP=0
    wait_idle(0);
    push(0, 32'hFFFF0000, w);
    push(0, 32'h0000FFFF, w);
    wait_high(0, run);
    check("t2_comen_run", run, 64);
    wait_rx(0, 2);
    check("t2_rx_count", rxq0.size(), 2);
    if (rxq0.size() >= 2) begin
      check("t2_rx_word0", rxq0.pop_front(), 32'hFFFF0000);
      check("t2_rx_word1", rxq0.pop_front(), 32'h0000FFFF);
    end

    // Gap spacing with GAP=3: GAP cycles plus one idle cycle
    push(3, 32'h13579BDF, w);
    push(3, 32'h2468ACE0, w);
    wait_high(3, run);
    check("t3_frame0_len", run, 32);
    count_low(3, run);
    check("t3_low_cycles", run, 4);
    count_high(3, run);
    check("t3_frame1_len", run, 32);
    wait_rx(3, 2);
    check("t3_rx_count", rxq3.size(), 2);
    if (rxq3.size() >= 2) begin
      check("t3_rx_word0", rxq3.pop_front(), 32'h13579BDF);
      check("t3_rx_word1", rxq3.pop_front(), 32'h2468ACE0);
    end

    // FIFO full: word 1 is popped at once, 2..5 fill the FIFO, 6 waits for
    // the pop at the end of frame 1.
    wait_idle(0);
    for (int i = 0; i < 6; i++) push(0, 32'(i + 1), wts[i]);
    for (int i = 0; i < 5; i++) check($sformatf("t4_wait_%0d", i + 1), wts[i], 0);
    check("t4_wait_6", wts[5], 29);
    wait_rx(0, 6);
    check("t4_rx_count", rxq0.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (rxq0.size() > 0) check($sformatf("t4_rx_%0d", i), rxq0.pop_front(), 32'(i + 1));
    end

    // Push and pop on the same edge at count=DEPTH-1
    wait_idle(0);
    words[0] = 32'hDEAD0001; words[1] = 32'hBEEF0002; words[2] = 32'hC0DE0003;
    words[3] = 32'hFACE0004; words[4] = 32'h0BAD0005; words[5] = 32'h1234ABCD;
    for (int i = 0; i < 4; i++) push(0, words[i], wts[i]);
    repeat (29) @(negedge clk);
    push(0, words[4], wts[4]);
    push(0, words[5], wts[5]);
    check("t6_wait_e", wts[4], 0);
    check("t6_wait_f", wts[5], 0);
    @(negedge clk);
    check("t6_full_after_f", wr0, 0);
    wait_rx(0, 6);
    check("t6_rx_count", rxq0.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (rxq0.size() > 0) check($sformatf("t6_rx_%0d", i), rxq0.pop_front(), words[i]);
    end

    // Reset mid-word with two words still queued
    wait_idle(3);
    push(3, 32'h12345678, w);
    push(3, 32'hAAAA5555, w);
    push(3, 32'h5555AAAA, w);
    repeat (12) @(negedge clk);
    check("t5_midword_comen", ce3, 1);
    rst3 = 1'b1;
    #1;
    check("t5_rst_outs", {ce3, do3, busy3, ws3, wr3}, 32'b00001);
    repeat (2) @(negedge clk);
    rst3 = 1'b0;
    hi = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      hi = hi + int'(ce3);
    end
    check("t5_no_frame", hi, 0);
    check("t5_busy_after", busy3, 0);
    check("t5_rx_none", rxq3.size(), 0);
    push(3, 32'hCAFEF00D, w);
    wait_high(3, run);
    check("t5_new_frame_len", run, 32);
    wait_rx(3, 1);
    check("t5_rx_count", rxq3.size(), 1);
    if (rxq3.size() > 0) check("t5_rx_word", rxq3.pop_front(), 32'hCAFEF00D);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
